uart_time_reporter: RTL and testbench
=====================================

UART_TIME_REPORTER -- requirements
Module: uart_time_reporter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning line rate; divisor DIV = CLK_HZ/BAUD (integer, truncated), DIV >= 2.
REQ-003 SHALL have parameter NUM_FIELDS, default 6, range 1..6, meaning number of two-digit fields reported.
REQ-004 SHALL have parameter SEP, default 8'h3A (':'), meaning the ASCII separator sent between fields.
REQ-005 SHALL have parameter ADD_CRLF, default 1, meaning append 8'h0D, 8'h0A after the last field when 1.
REQ-006 SHALL have parameter STOP_BITS, default 1, range 1..2, meaning stop bits per character.
REQ-007 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-008 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-009 SHALL have port start  input  1  request one report; sampled each clk.
REQ-010 SHALL have port fields  input  7*NUM_FIELDS  packed binary values 0..99; field k at [7k+6:7k]; field NUM_FIELDS-1 sent first.
REQ-011 SHALL have port uart  output  1  serial line, 8N1 (or 8N2), idle high.
REQ-012 SHALL have port busy  output  1  high while a report is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at report completion.

Function
REQ-014 start SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored, neither queued nor restarting.
REQ-015 On acceptance, fields SHALL be snapshotted in the same cycle; later changes to fields SHALL NOT affect the report in progress.
REQ-016 Each snapshotted field value > 99 SHALL be clamped to 99; each field SHALL be sent as two ASCII digits, tens then units (8'h30 + digit), with a leading zero kept.
REQ-017 The character sequence SHALL be: per field two digits; SEP between consecutive fields, none after the last; then CR, LF if ADD_CRLF=1; total characters = 3*NUM_FIELDS - 1 + 2*ADD_CRLF.
REQ-018 Each character SHALL be framed as 1 start bit (0), 8 data bits LSB first, then STOP_BITS stop bits (1); each bit SHALL last exactly DIV clk cycles.
REQ-019 The baud counter SHALL restart at 0 on acceptance so that the first start bit is full width; characters SHALL be sent back-to-back with no idle gap.
REQ-020 busy and uart=0 (start bit) SHALL appear in the cycle after start is sampled high.
REQ-021 The FSM SHALL have states IDLE -> START_BIT -> DATA_BITS (bit index 0..7) -> STOP_BIT (count 1..STOP_BITS) -> START_BIT for the next character, or -> IDLE after the last character.
REQ-022 On the cycle the last stop bit of the last character completes, the FSM SHALL return to IDLE; in the following cycle busy=0, done=1 for exactly one cycle, and uart=1.
REQ-023 start may be accepted in the cycle done=1, beginning a new report with no extra idle time.
REQ-024 Report duration from acceptance to done SHALL be characters*(9+STOP_BITS)*DIV + 1 clk cycles.
REQ-025 In IDLE, uart SHALL be 1 and the baud counter held at 0.

Reset
REQ-026 While rst=1, on every clk: state=IDLE, uart=1, busy=0, done=0, character index, bit index and baud counter = 0; start SHALL be ignored.
REQ-027 rst asserted mid-report SHALL abort it in the next cycle (uart=1 even if mid-bit), with no done pulse and no resumption after rst is released.
REQ-028 The first start SHALL be accepted in the first cycle with rst=0.

Verification (CLK_HZ=1000, BAUD=100, DIV=10 unless noted)
REQ-029 NUM_FIELDS=5, fields {24,6,9,13,5} (year first), pulse start -> uart decodes "24:06:09:13:05\r\n" (16 chars), done one cycle at 1601 cycles after acceptance.
REQ-030 NUM_FIELDS=1, ADD_CRLF=0, field 7 -> uart sends 8'h30, 8'h37 only; busy high for exactly 200 cycles.
REQ-031 Field value 127 -> sent as "99"; field 0 -> sent as "00".
REQ-032 Second start pulse at 300 cycles into a report, plus fields changed at 50 cycles -> report unchanged, single done, no second report.
REQ-033 rst pulsed 1 cycle at 450 cycles into a report -> uart=1 from the next cycle, busy=0, no done; new start afterwards -> full correct report.
REQ-034 STOP_BITS=2, start held high continuously -> each character 11 bit-times (110 cycles); consecutive reports separated only by the done cycle.

Source files
------------

// File: rtl/uart_time_reporter.sv
`default_nettype none
// ============================================================================
// uart_time_reporter : serialises NUM_FIELDS clamped two-digit decimal fields  | rev 1.0
// ============================================================================
module uart_time_reporter #(
   parameter int         CLK_HZ     = 50_000_000,
   parameter int         BAUD       = 9600,
   parameter int         NUM_FIELDS = 6,
   parameter logic [7:0] SEP        = 8'h3A,
   parameter int         ADD_CRLF   = 1,
   parameter int         STOP_BITS  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [7*NUM_FIELDS-1:0] fields,
   output logic                    uart,
   output logic                    busy,
   output logic                    done
);

   localparam int              DIV       = CLK_HZ / BAUD;
   localparam int              CW        = $clog2(DIV);
   localparam logic [CW-1:0]   DIV_M1    = CW'(DIV - 1);
   localparam logic [2:0]      LAST_FLD  = 3'(NUM_FIELDS - 1);
   localparam logic [1:0]      LAST_POS  = (ADD_CRLF != 0) ? 2'd3 : 2'd1;
   localparam logic [1:0]      STOP_LAST = 2'(STOP_BITS);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA_BITS = 2'd2,
      STOP_BIT  = 2'd3
   } state_t;

   state_t                  state, state_n;
   logic [CW-1:0]           baud_cnt;
   logic [2:0]              bit_idx;
   logic [1:0]              stop_cnt;
   logic [2:0]              fld, fld_n;
   logic [1:0]              pos, pos_n;
   logic [7:0]              chr, chr_n;
   logic [4*NUM_FIELDS-1:0] tens_q, units_q;
   logic [3:0]              tens_sel, units_sel;
   logic                    uart_n, done_n, adv_char;
   logic                    accept, bit_end, last_char;

   function automatic logic [6:0] clamp99(input logic [6:0] v);
      return (v > 7'd99) ? 7'd99 : v;
   endfunction

   function automatic logic [3:0] tens_of(input logic [6:0] v);
      logic [6:0] q;
      q = clamp99(v) / 7'd10;
      return q[3:0];
   endfunction

   function automatic logic [3:0] units_of(input logic [6:0] v);
      logic [6:0] r;
      r = clamp99(v) % 7'd10;
      return r[3:0];
   endfunction

   assign accept    = (state == IDLE) && start;
   assign bit_end   = (baud_cnt == DIV_M1);
   assign last_char = (fld == LAST_FLD) && (pos == LAST_POS);
   assign busy      = (state != IDLE);

   // Character position: pos 0/1 = tens/units, 2 = SEP (or CR on the last field), 3 = LF
   always_comb begin
      fld_n = fld;
      pos_n = pos + 2'd1;
      if (pos == 2'd2 && fld != LAST_FLD) begin
         fld_n = fld + 3'd1;
         pos_n = 2'd0;
      end
   end

   always_comb begin
      tens_sel  = 4'd0;
      units_sel = 4'd0;
      for (int k = 0; k < NUM_FIELDS; k++) begin
         if (k == NUM_FIELDS - 1 - int'(fld_n)) begin
            tens_sel  = tens_q[4*k +: 4];
            units_sel = units_q[4*k +: 4];
         end
      end
      case (pos_n)
         2'd0:    chr_n = {4'h3, tens_sel};
         2'd1:    chr_n = {4'h3, units_sel};
         2'd2:    chr_n = (fld_n == LAST_FLD) ? 8'h0D : SEP;
         default: chr_n = 8'h0A;
      endcase
   end

   // uart is registered, so each branch produces the level for the next cycle
   always_comb begin
      state_n  = state;
      uart_n   = 1'b1;
      done_n   = 1'b0;
      adv_char = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = START_BIT;
               uart_n  = 1'b0;
            end
         end
         START_BIT: begin
            uart_n = 1'b0;
            if (bit_end) begin
               state_n = DATA_BITS;
               uart_n  = chr[0];
            end
         end
         DATA_BITS: begin
            uart_n = chr[bit_idx];
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
                  state_n = STOP_BIT;
                  uart_n  = 1'b1;
               end else begin
                  uart_n = chr[bit_idx + 3'd1];
               end
            end
         end
         STOP_BIT: begin
            if (bit_end && stop_cnt == STOP_LAST) begin
               if (last_char) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n  = START_BIT;
                  uart_n   = 1'b0;
                  adv_char = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         uart     <= 1'b1;
         done     <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         stop_cnt <= 2'd0;
         fld      <= 3'd0;
         pos      <= 2'd0;
         chr      <= 8'd0;
         tens_q   <= '0;
         units_q  <= '0;
      end else begin
         state <= state_n;
         uart  <= uart_n;
         done  <= done_n;

         if (state == IDLE || bit_end) baud_cnt <= '0;
         else                          baud_cnt <= baud_cnt + CW'(1);

         if (state == DATA_BITS && bit_end) bit_idx <= bit_idx + 3'd1;

         if (state == DATA_BITS && bit_end && bit_idx == 3'd7) stop_cnt <= 2'd1;
         else if (state == STOP_BIT && bit_end)                 stop_cnt <= stop_cnt + 2'd1;

         if (accept) begin
            fld <= 3'd0;
            pos <= 2'd0;
            chr <= {4'h3, tens_of(fields[7*(NUM_FIELDS-1) +: 7])};
            for (int k = 0; k < NUM_FIELDS; k++) begin
               tens_q[4*k +: 4]  <= tens_of(fields[7*k +: 7]);
               units_q[4*k +: 4] <= units_of(fields[7*k +: 7]);
            end
         end else if (adv_char) begin
            fld <= fld_n;
            pos <= pos_n;
            chr <= chr_n;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_time_reporter.sv
`default_nettype none
// ============================================================================
// tb_uart_time_reporter : scoreboard bench decoding three reporter instances  | rev 1.0
// ============================================================================
module tb_uart_time_reporter;

   localparam int CLK_HZ = 1000;
   localparam int BAUD   = 100;
   localparam int DIV    = CLK_HZ / BAUD;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b, start_c;
   logic [34:0] fields_a;
   logic [6:0]  fields_b;
   logic [13:0] fields_c;
   logic        uart_a, busy_a, done_a;
   logic        uart_b, busy_b, done_b;
   logic        uart_c, busy_c, done_c;
   logic        mon_flush;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];

   always #5 clk = ~clk;

   uart_time_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_FIELDS(5), .SEP(8'h3A),
                        .ADD_CRLF(1), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .fields(fields_a),
      .uart(uart_a), .busy(busy_a), .done(done_a));

   uart_time_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_FIELDS(1), .SEP(8'h3A),
                        .ADD_CRLF(0), .STOP_BITS(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .fields(fields_b),
      .uart(uart_b), .busy(busy_b), .done(done_b));

   uart_time_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_FIELDS(2), .SEP(8'h3A),
                        .ADD_CRLF(1), .STOP_BITS(2)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .fields(fields_c),
      .uart(uart_c), .busy(busy_c), .done(done_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic get_line(input int sel);
      case (sel)
         0:       return uart_a;
         1:       return uart_b;
         default: return uart_c;
      endcase
   endfunction

   function automatic logic get_done(input int sel);
      case (sel)
         0:       return done_a;
         1:       return done_b;
         default: return done_c;
      endcase
   endfunction

   function automatic int q_size(input int sel);
      case (sel)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [7:0] q_pop(input int sel);
      case (sel)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic push_char(input int sel, input logic [7:0] c);
      case (sel)
         0:       q0.push_back(c);
         1:       q1.push_back(c);
         default: q2.push_back(c);
      endcase
   endtask

   // Reference text of one report: fields highest index first, clamped, "tt:uu..." then CR LF
   task automatic push_report(input int sel, input int nf, input bit crlf, input logic [41:0] f);
      for (int k = nf - 1; k >= 0; k--) begin
         int v;
         v = int'(f[7*k +: 7]);
         if (v > 99) v = 99;
         push_char(sel, 8'(48 + v / 10));
         push_char(sel, 8'(48 + v % 10));
         if (k != 0) push_char(sel, 8'h3A);
      end
      if (crlf) begin
         push_char(sel, 8'h0D);
         push_char(sel, 8'h0A);
      end
   endtask

   task automatic wait_mon(input int n, input int sel, inout bit ab);
      repeat (n) begin
         @(negedge clk);
         if (sel == 0 && mon_flush) ab = 1'b1;
      end
   endtask

   // Serial decoder: find the start-bit edge, then sample every bit at its middle
   task automatic monitor(input int sel, input int sb);
      logic [7:0] b;
      bit         ab;
      forever begin
         @(negedge clk);
         if (get_line(sel) === 1'b0 && !(sel == 0 && mon_flush)) begin
            ab = 1'b0;
            b  = 8'd0;
            wait_mon(DIV / 2 - 1, sel, ab);
            if (!ab) check($sformatf("start_bit_%0d", sel), 32'(get_line(sel)), 32'd0);
            for (int i = 0; i < 8; i++) begin
               wait_mon(DIV, sel, ab);
               b[i] = get_line(sel);
            end
            for (int s = 0; s < sb; s++) begin
               wait_mon(DIV, sel, ab);
               if (!ab) check($sformatf("stop_bit_%0d", sel), 32'(get_line(sel)), 32'd1);
            end
            if (!ab) begin
               check($sformatf("char_expected_%0d", sel), 32'(q_size(sel) > 0), 32'd1);
               if (q_size(sel) > 0) check($sformatf("char_%0d", sel), 32'(b), 32'(q_pop(sel)));
            end
         end
      end
   endtask

   initial monitor(0, 1);
   initial monitor(1, 1);
   initial monitor(2, 2);

   task automatic step(inout int cyc);
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_done(input int sel, inout int cyc, input int limit, output bit seen);
      while (get_done(sel) !== 1'b1 && cyc < limit) step(cyc);
      seen = (get_done(sel) === 1'b1);
   endtask

   task automatic pulse_a(inout int cyc);
      start_a = 1'b1;
      cyc     = 0;
      step(cyc);
      start_a = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int cnt;
      int t;
      bit seen;

      rst       = 1'b1;
      start_a   = 1'b1;
      start_b   = 1'b0;
      start_c   = 1'b0;
      mon_flush = 1'b0;
      fields_a  = {7'd24, 7'd6, 7'd9, 7'd13, 7'd5};
      fields_b  = 7'd7;
      fields_c  = {7'd59, 7'd8};

      // reset held with start high: nothing may start
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy_a !== 1'b0 || done_a !== 1'b0 || uart_a !== 1'b1) cnt++;
      end
      check("reset_quiet_cycles", 32'(cnt), 32'd0);
      check("reset_uart", 32'(uart_a), 32'd1);
      check("reset_busy", 32'(busy_a), 32'd0);
      check("reset_done", 32'(done_a), 32'd0);

      // report 1: accepted in the first cycle after reset release
      push_report(0, 5, 1'b1, 42'(fields_a));
      rst = 1'b0;
      cyc = 0;
      step(cyc);
      start_a = 1'b0;
      check("t1_busy_cycle1", 32'(busy_a), 32'd1);
      check("t1_uart_cycle1", 32'(uart_a), 32'd0);
      wait_done(0, cyc, 3000, seen);
      check("t1_done_seen", 32'(seen), 32'd1);
      check("t1_done_cycle", 32'(cyc), 32'd1601);
      check("t1_busy_at_done", 32'(busy_a), 32'd0);
      check("t1_uart_at_done", 32'(uart_a), 32'd1);
      check("t1_queue_drained", 32'(q_size(0)), 32'd0);
      step(cyc);
      check("t1_done_one_cycle", 32'(done_a), 32'd0);

      // report 2: clamping, snapshot isolation, start ignored while busy
      repeat (3) @(negedge clk);
      fields_a = {7'd127, 7'd0, 7'd99, 7'd100, 7'd45};
      push_report(0, 5, 1'b1, 42'(fields_a));
      pulse_a(cyc);
      check("t2_busy_cycle1", 32'(busy_a), 32'd1);
      while (cyc < 50) step(cyc);
      fields_a = {7'd1, 7'd2, 7'd3, 7'd4, 7'd5};
      while (cyc < 300) step(cyc);
      start_a = 1'b1;
      step(cyc);
      start_a = 1'b0;
      wait_done(0, cyc, 3000, seen);
      check("t2_done_seen", 32'(seen), 32'd1);
      check("t2_done_cycle", 32'(cyc), 32'd1601);
      check("t2_queue_drained", 32'(q_size(0)), 32'd0);
      cnt = 0;
      repeat (40) begin
         step(cyc);
         if (busy_a !== 1'b0 || done_a !== 1'b0) cnt++;
      end
      check("t2_no_second_report", 32'(cnt), 32'd0);

      // report 3: aborted by a one-cycle reset during a low data bit
      fields_a = {7'd10, 7'd20, 7'd30, 7'd40, 7'd50};
      push_report(0, 5, 1'b1, 42'(fields_a));
      pulse_a(cyc);
      while (cyc < 450) step(cyc);
      check("t3_line_low_before_rst", 32'(uart_a), 32'd0);
      mon_flush = 1'b1;
      rst       = 1'b1;
      step(cyc);
      check("t3_uart_after_rst", 32'(uart_a), 32'd1);
      check("t3_busy_after_rst", 32'(busy_a), 32'd0);
      check("t3_done_after_rst", 32'(done_a), 32'd0);
      rst = 1'b0;
      q0.delete();
      cnt = 0;
      repeat (1700) begin
         step(cyc);
         if (done_a !== 1'b0 || busy_a !== 1'b0 || uart_a !== 1'b1) cnt++;
      end
      check("t3_no_resume", 32'(cnt), 32'd0);
      mon_flush = 1'b0;

      // report 4: full report after the abort
      fields_a = {7'd0, 7'd59, 7'd58, 7'd23, 7'd99};
      push_report(0, 5, 1'b1, 42'(fields_a));
      pulse_a(cyc);
      check("t4_busy_cycle1", 32'(busy_a), 32'd1);
      wait_done(0, cyc, 3000, seen);
      check("t4_done_cycle", 32'(cyc), 32'd1601);
      check("t4_queue_drained", 32'(q_size(0)), 32'd0);

      // single field, no CR/LF: "07" only, busy for 200 cycles
      push_report(1, 1, 1'b0, 42'(fields_b));
      start_b = 1'b1;
      cyc = 0;
      step(cyc);
      start_b = 1'b0;
      cnt = 0;
      t   = 0;
      while (done_b !== 1'b1 && t < 1000) begin
         if (busy_b === 1'b1) cnt++;
         step(cyc);
         t++;
      end
      check("b_busy_cycles", 32'(cnt), 32'd200);
      check("b_done_cycle", 32'(cyc), 32'd201);
      check("b_queue_drained", 32'(q_size(1)), 32'd0);

      // two stop bits, start held high: reports separated only by the done cycle
      repeat (3) push_report(2, 2, 1'b1, 42'(fields_c));
      start_c = 1'b1;
      cyc = 0;
      step(cyc);
      for (int r = 0; r < 3; r++) begin
         check($sformatf("c_busy_start_r%0d", r), 32'(busy_c), 32'd1);
         cnt = 0;
         t   = 0;
         while (done_c !== 1'b1 && t < 2000) begin
            if (busy_c === 1'b1) cnt++;
            step(cyc);
            t++;
         end
         check($sformatf("c_busy_len_r%0d", r), 32'(cnt), 32'd770);
         check($sformatf("c_busy_at_done_r%0d", r), 32'(busy_c), 32'd0);
         if (r == 2) start_c = 1'b0;
         step(cyc);
      end
      cnt = 0;
      repeat (20) begin
         if (busy_c !== 1'b0) cnt++;
         step(cyc);
      end
      check("c_idle_after_last", 32'(cnt), 32'd0);
      check("c_queue_drained", 32'(q_size(2)), 32'd0);
      check("final_queue_a", 32'(q_size(0)), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
